xmit_frame_feeder: RTL
======================

# xmit_frame_feeder

Store-and-forward framer on the `clk_sys` domain, directly upstream of `xmitTop`. It accepts a byte stream delimited by start/end-of-frame markers and buffers each whole frame so the byte count is known. It then presents the frame to `xmitTop` in the form that block consumes: a 24-bit control block on the first byte, followed by contiguous bytes at one per cycle. Malformed, out-of-range and overflowing frames are dropped here, so `xmitTop` only ever sees complete frames.

## Interface
- `DATA_DEPTH`, 2048: byte buffer entries; power of two.
- `LEN_DEPTH`, 16: committed-frame descriptor FIFO entries; power of two.
- `MIN_LEN`, 64: minimum legal frame length in bytes.
- `MAX_LEN`, 1518: maximum legal frame length in bytes; must be ≤ 4095.

Ports:
- `clk_sys`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input byte strobe.
- `in_sop`  in  1  first byte of frame; qualified by `in_valid`.
- `in_eop`  in  1  last byte of frame; qualified by `in_valid`.
- `in_data`  in  8  input byte.
- `in_hi_priority`  in  1  frame priority; sampled on the sop byte.
- `xmit_ready`  in  1  downstream may accept a new frame.
- `f_data_in`  out  8  byte to `xmitTop`.
- `f_rec_data_valid`  out  1  `f_data_in` valid.
- `f_rec_frame_valid`  out  1  high on the first byte of each frame only.
- `f_ctrl_in`  out  24  control block; valid with `f_rec_frame_valid`, zero otherwise.
- `f_hi_priority`  out  1  priority of the frame being streamed; held for the whole frame.
- `frames_pending`  out  $clog2(LEN_DEPTH)+1  number of committed frames not yet started.

## Operation
- **Write FSM:**
  - `WR_IDLE`: `in_valid & in_sop` → `WR_FRAME`. The byte is written and the count set to 1. If the descriptor FIFO is full, go to `WR_DROP` instead.
  - `WR_FRAME`: each valid byte is written at the speculative pointer and the count is incremented.
  - Leaving `WR_FRAME` on eop: if MIN_LEN ≤ count ≤ MAX_LEN, commit by pushing {len, priority} and advancing the committed pointer; then → `WR_IDLE`. Otherwise rewind the speculative pointer to the committed pointer and count a drop.
  - `WR_DROP`: discard bytes until eop → `WR_IDLE`.
- **Drops inside `WR_FRAME`:**
  - Buffer full (speculative pointer − read pointer == DATA_DEPTH) on a valid byte → rewind, → `WR_DROP`.
  - count would exceed MAX_LEN → rewind, → `WR_DROP`.
- **sop inside `WR_FRAME`:** abort the current frame (rewind, count a drop) and start the new frame with this byte.
- **sop inside `WR_DROP`:** start a new frame.
- **Stray input:** eop or a plain byte in `WR_IDLE` is ignored.
- **sop&eop in one cycle:** this is a one-byte frame, handled by the length rules (dropped when MIN_LEN > 1).
- **Read FSM:**
  - `RD_IDLE`: if descriptors are available (`frames_pending` ≠ 0) and `xmit_ready` → `RD_STREAM`. Pop the descriptor, emit the first byte with `f_rec_frame_valid`=1 and `f_ctrl_in` = {len[11:0], len[11:0]}, and latch `f_hi_priority`.
  - `RD_STREAM`: emit one byte per cycle, never stalling, until len bytes have been emitted.
  - After the last byte: if another descriptor is available and `xmit_ready` is high, its first byte is emitted on the very next cycle (no gap). Otherwise → `RD_IDLE`.
- **Simultaneous events:**
  - A commit and a pop in the same cycle leave `frames_pending` unchanged.
  - A buffer-full check uses the read pointer registered at the start of the cycle.

## Timing
- All outputs are registered.
- Reset values: `f_data_in`=0, `f_rec_data_valid`=0, `f_rec_frame_valid`=0, `f_ctrl_in`=0, `f_hi_priority`=0, `frames_pending`=0.
- All pointers, FSMs and the FIFOs are cleared on reset. A partial frame in progress at reset is lost.
- **Latency:** with an eop byte accepted at edge N, an empty buffer and `xmit_ready`=1, `f_rec_frame_valid` is high after edge N+2.
- **`xmit_ready`** is sampled only at frame boundaries. Deasserting it mid-frame has no effect.
- **`frames_pending`** updates the cycle after a commit or pop.
- **Address wrap-around:** addresses wrap modulo DATA_DEPTH. Pointers carry one extra bit to distinguish full from empty.

## Configuration
- `XMIT_FEEDER_DROP_CNT_EN`:
  - Defined: adds output port `drop_cnt` (out, 16). It increments by 1 per dropped or aborted frame, saturates at 16'hFFFF, and resets to 0.
  - Undefined: the port and the counter are absent; drop behaviour is otherwise identical.

## Test plan
- **Single frame:** 512-byte frame with bytes 0..255,0..255, priority 1, `xmit_ready`=1 → `f_ctrl_in`=24'h200200 on the first byte, 512 contiguous valid bytes in order, `f_hi_priority`=1 throughout.
- **Back-to-back:** 16 back-to-back 512-byte frames → 16 control blocks, each exactly 512 cycles apart, with no idle cycle between frames.
- **Length limits:**
  - A 63-byte frame and a 1519-byte frame are both dropped, with nothing emitted; `drop_cnt`=2 when the macro is defined.
  - A 64-byte frame and a 1518-byte frame are emitted with ctrl 24'h040040 and 24'h5EE5EE.
- **Abort and stray input:**
  - sop at byte 100 of a frame → the first frame is discarded and the second is emitted intact.
  - An eop with no preceding sop is ignored.
- **Backpressure and overflow:**
  - Hold `xmit_ready`=0 while writing 3 × 1000-byte frames with DATA_DEPTH=2048 → the third frame is dropped on overflow and `frames_pending`=2.
  - Then raise `xmit_ready` → two frames are emitted.
- **Reset mid-operation:** assert `reset` low during streaming at byte 200 → all outputs go to 0 immediately and no further output appears. The next frame after release is emitted normally.

Source files
------------

// File: rtl/xmit_frame_feeder.sv
// Store-and-forward framer feeding xmitTop: buffers whole frames, drops bad ones, streams each with a length control block.
// Defining XMIT_FEEDER_DROP_CNT_EN adds the saturating drop_cnt output.
module xmit_frame_feeder #(
  parameter int DATA_DEPTH = 2048,
  parameter int LEN_DEPTH  = 16,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic [7:0]                 in_data,
  input  logic                       in_hi_priority,
  input  logic                       xmit_ready,
  output logic [7:0]                 f_data_in,
  output logic                       f_rec_data_valid,
  output logic                       f_rec_frame_valid,
  output logic [23:0]                f_ctrl_in,
  output logic                       f_hi_priority,
  output logic [$clog2(LEN_DEPTH):0] frames_pending
`ifdef XMIT_FEEDER_DROP_CNT_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int LW = $clog2(LEN_DEPTH);
  localparam logic [AW:0]   DEPTH_P     = (AW+1)'(DATA_DEPTH);
  localparam logic [AW:0]   PTR_ONE     = (AW+1)'(1);
  localparam logic [LW-1:0] DESC_ONE    = LW'(1);
  localparam logic [LW+1:0] LEN_DEPTH_P = (LW+2)'(LEN_DEPTH);
  localparam logic [11:0]   MIN_L       = 12'(MIN_LEN);
  localparam logic [11:0]   MAX_L       = 12'(MAX_LEN);

  typedef enum logic [1:0] {WR_IDLE, WR_FRAME, WR_DROP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

  logic [7:0]  data_mem [DATA_DEPTH];
  logic [12:0] desc_mem [LEN_DEPTH];  // {priority, length}

  wr_state_t   wr_state, st_nxt;
  rd_state_t   rd_state;
  logic [AW:0] wr_spec_ptr, wr_commit_ptr, rd_ptr, spec_nxt;
  logic [11:0] cnt, cnt_nxt, commit_len, rd_remain;
  logic        cur_prio, prio_nxt;
  logic        wr_en, commit, pop;
  logic [AW-1:0] wr_addr;
  logic        stage_valid;
  logic [12:0] stage_desc, head;
  logic [LW-1:0] desc_wr_ptr, desc_rd_ptr;
  logic [LW+1:0] desc_occ;
  logic        desc_full, start_full, spec_full, start_ok;

  // A just-committed descriptor sits one cycle in the stage register, so it must count toward fullness.
  assign desc_occ   = {1'b0, frames_pending} + (LW+2)'(stage_valid);
  assign desc_full  = desc_occ >= LEN_DEPTH_P;
  assign start_full = (wr_commit_ptr - rd_ptr) == DEPTH_P;
  assign spec_full  = (wr_spec_ptr - rd_ptr) == DEPTH_P;
  assign start_ok   = !desc_full && !start_full;

  assign head = desc_mem[desc_rd_ptr];
  assign pop  = xmit_ready && (frames_pending != '0) &&
                (rd_state == RD_IDLE || rd_remain == 12'd0);

  always_comb begin
    st_nxt     = wr_state;
    spec_nxt   = wr_spec_ptr;
    cnt_nxt    = cnt;
    prio_nxt   = cur_prio;
    wr_en      = 1'b0;
    wr_addr    = wr_spec_ptr[AW-1:0];
    commit     = 1'b0;
    commit_len = cnt + 12'd1;
    if (in_valid && in_sop) begin
      // A sop always restarts at the committed pointer, abandoning any partial frame.
      spec_nxt = wr_commit_ptr;
      st_nxt   = in_eop ? WR_IDLE : WR_DROP;
      if (start_ok) begin
        wr_en      = 1'b1;
        wr_addr    = wr_commit_ptr[AW-1:0];
        cnt_nxt    = 12'd1;
        prio_nxt   = in_hi_priority;
        commit_len = 12'd1;
        if (!in_eop) begin
          st_nxt   = WR_FRAME;
          spec_nxt = wr_commit_ptr + PTR_ONE;
        end else if (MIN_LEN <= 1) begin
          commit   = 1'b1;
          spec_nxt = wr_commit_ptr + PTR_ONE;
        end
      end
    end else if (in_valid && wr_state == WR_FRAME) begin
      if (spec_full || cnt == MAX_L) begin
        spec_nxt = wr_commit_ptr;
        st_nxt   = in_eop ? WR_IDLE : WR_DROP;
      end else begin
        wr_en    = 1'b1;
        spec_nxt = wr_spec_ptr + PTR_ONE;
        cnt_nxt  = commit_len;
        if (in_eop) begin
          st_nxt = WR_IDLE;
          if (commit_len >= MIN_L) commit = 1'b1;
          else spec_nxt = wr_commit_ptr;
        end
      end
    end else if (in_valid && in_eop && wr_state == WR_DROP) begin
      st_nxt = WR_IDLE;
    end
  end

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      wr_state       <= WR_IDLE;
      wr_spec_ptr    <= '0;
      wr_commit_ptr  <= '0;
      cnt            <= '0;
      cur_prio       <= 1'b0;
      stage_valid    <= 1'b0;
      stage_desc     <= '0;
      desc_wr_ptr    <= '0;
      frames_pending <= '0;
    end else begin
      wr_state    <= st_nxt;
      wr_spec_ptr <= spec_nxt;
      cnt         <= cnt_nxt;
      cur_prio    <= prio_nxt;
      stage_valid <= commit;
      stage_desc  <= {prio_nxt, commit_len};
      if (commit) wr_commit_ptr <= spec_nxt;
      if (stage_valid) desc_wr_ptr <= desc_wr_ptr + DESC_ONE;
      frames_pending <= frames_pending + {{LW{1'b0}}, stage_valid} - {{LW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en) data_mem[wr_addr] <= in_data;
    if (stage_valid) desc_mem[desc_wr_ptr] <= stage_desc;
  end

  // rd_remain counts bytes still to send after the one currently on f_data_in.
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      rd_state          <= RD_IDLE;
      rd_ptr            <= '0;
      desc_rd_ptr       <= '0;
      rd_remain         <= '0;
      f_data_in         <= '0;
      f_rec_data_valid  <= 1'b0;
      f_rec_frame_valid <= 1'b0;
      f_ctrl_in         <= '0;
      f_hi_priority     <= 1'b0;
    end else if (pop) begin
      rd_state          <= RD_STREAM;
      rd_ptr            <= rd_ptr + PTR_ONE;
      desc_rd_ptr       <= desc_rd_ptr + DESC_ONE;
      rd_remain         <= head[11:0] - 12'd1;
      f_data_in         <= data_mem[rd_ptr[AW-1:0]];
      f_rec_data_valid  <= 1'b1;
      f_rec_frame_valid <= 1'b1;
      f_ctrl_in         <= {head[11:0], head[11:0]};
      f_hi_priority     <= head[12];
    end else if (rd_state == RD_STREAM && rd_remain != 12'd0) begin
      rd_ptr            <= rd_ptr + PTR_ONE;
      rd_remain         <= rd_remain - 12'd1;
      f_data_in         <= data_mem[rd_ptr[AW-1:0]];
      f_rec_data_valid  <= 1'b1;
      f_rec_frame_valid <= 1'b0;
      f_ctrl_in         <= '0;
    end else begin
      rd_state          <= RD_IDLE;
      f_data_in         <= '0;
      f_rec_data_valid  <= 1'b0;
      f_rec_frame_valid <= 1'b0;
      f_ctrl_in         <= '0;
      f_hi_priority     <= 1'b0;
    end
  end

`ifdef XMIT_FEEDER_DROP_CNT_EN
  logic        abort_hit, reject_hit;
  logic [16:0] drop_sum;

  // An aborting sop can also be rejected itself, so two drops may land in one cycle.
  always_comb begin
    abort_hit  = in_valid && in_sop && (wr_state == WR_FRAME);
    reject_hit = 1'b0;
    if (in_valid && in_sop)
      reject_hit = !start_ok || (in_eop && (MIN_LEN > 1));
    else if (in_valid && wr_state == WR_FRAME)
      reject_hit = spec_full || (cnt == MAX_L) || (in_eop && commit_len < MIN_L);
    drop_sum = {1'b0, drop_cnt} + 17'(abort_hit) + 17'(reject_hit);
  end

  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) drop_cnt <= '0;
    else        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`endif

endmodule
